rename_unit: RTL and testbench

- Rename stage directly upstream of physical_registers in the OoO RISC-V core.
- Maps architectural rs1/rs2/rd to physical tags through a 32-entry map table.
- Allocates a fresh destination tag from a circular free list.
- Marks the new tag not-ready in the physical register file, and returns tags to the free list when commit retires an instruction.

---
 rtl/core_pkg.sv | 30 +++
 rtl/rename_unit_free_list.sv | 59 +++++
 rtl/rename_unit.sv | 119 +++++++++++
 tb/tb_rename_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared rename-stage types and sizing
// Purpose: architectural/physical register sizing, tag typedefs, renamed
// uop record and the free-list pointer wrap helper.
// Ports: none (package).
package core_pkg;

  localparam int NUM_ARCH = 32;
  localparam int NUM_PHYS = 128;
  localparam int AREG_W   = 5;
  localparam int PREG_W   = 7;
  localparam int FL_DEPTH = NUM_PHYS - NUM_ARCH;
  localparam int FL_CNT_W = $clog2(FL_DEPTH + 1);
  localparam int FL_PTR_W = $clog2(FL_DEPTH);

  typedef logic [AREG_W-1:0] areg_t;
  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    preg_t prs1;
    preg_t prs2;
    preg_t prd;
    preg_t old_prd;
  } renamed_uop_t;

  // Pointers run 0..FL_DEPTH-1; FL_DEPTH is not a power of two.
  function automatic logic [FL_PTR_W-1:0] fl_ptr_inc(input logic [FL_PTR_W-1:0] p);
    return (p == FL_PTR_W'(FL_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/rename_unit_free_list.sv
// rtl/rename_unit_free_list.sv - circular free list of physical tags
// Purpose: FIFO of unallocated physical tags, preloaded with NUM_ARCH..NUM_PHYS-1.
// Ports: clk, reset (async active-low), pop/head_tag (allocate from head),
// push/push_tag (return to tail), count, empty, full.
module free_list
  import core_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                pop,
  input  logic                push,
  input  logic [PREG_W-1:0]   push_tag,
  output logic [PREG_W-1:0]   head_tag,
  output logic [FL_CNT_W-1:0] count,
  output logic                empty,
  output logic                full
);

  preg_t               fl_q [FL_DEPTH];
  logic [FL_PTR_W-1:0] head_q;
  logic [FL_PTR_W-1:0] tail_q;
  logic [FL_CNT_W-1:0] count_q;
  logic                do_pop;
  logic                do_push;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FL_CNT_W'(FL_DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && !full;
  // Head tag comes from the pre-edge head, so a tag pushed this cycle is
  // never handed out in the same cycle.
  assign head_tag = fl_q[head_q];
  assign count    = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        fl_q[i] <= preg_t'(NUM_ARCH + i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= FL_CNT_W'(FL_DEPTH);
    end else begin
      if (do_push) begin
        fl_q[tail_q] <= push_tag;
        tail_q       <= fl_ptr_inc(tail_q);
      end
      if (do_pop) begin
        head_q <= fl_ptr_inc(head_q);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/rename_unit.sv
// rtl/rename_unit.sv - register rename stage
// Purpose: maps rs1/rs2/rd to physical tags via the map table, allocates
// destination tags from the free list, pulses set_not_rdy to the PRF and
// returns committed old tags to the free list.
// Ports: clk, reset (async active-low); in_valid/in_ready with rs1, rs2, rd,
// rd_wen; out_valid/out_ready with prs1, prs2, prd, old_prd; prf_set_not_rdy,
// prf_target_reg; commit_free, commit_old_prd; free_count.
module rename_unit
  import core_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [AREG_W-1:0]   rs1,
  input  logic [AREG_W-1:0]   rs2,
  input  logic [AREG_W-1:0]   rd,
  input  logic                rd_wen,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PREG_W-1:0]   prs1,
  output logic [PREG_W-1:0]   prs2,
  output logic [PREG_W-1:0]   prd,
  output logic [PREG_W-1:0]   old_prd,
  output logic                prf_set_not_rdy,
  output logic [PREG_W-1:0]   prf_target_reg,
  input  logic                commit_free,
  input  logic [PREG_W-1:0]   commit_old_prd,
  output logic [FL_CNT_W-1:0] free_count
);

  preg_t        map_q [NUM_ARCH];
  renamed_uop_t uop_q;
  logic         out_valid_q;
  logic         pulse_q;
  preg_t        target_q;

  logic         needs_alloc;
  logic         accept;
  logic         alloc;
  logic         free_req;
  logic         fl_push;
  logic         fl_empty;
  logic         fl_full;
  preg_t        fl_head;

  assign needs_alloc = rd_wen && (rd != '0);
  // Empty check uses the registered count: a same-cycle free does not help.
  assign in_ready    = reset && (!out_valid_q || out_ready) && (!needs_alloc || !fl_empty);
  assign accept      = in_valid && in_ready;
  assign alloc       = accept && needs_alloc;
  assign free_req    = commit_free && (commit_old_prd != '0);
  assign fl_push     = free_req && !fl_full;

  free_list u_free_list (
    .clk      (clk),
    .reset    (reset),
    .pop      (alloc),
    .push     (fl_push),
    .push_tag (commit_old_prd),
    .head_tag (fl_head),
    .count    (free_count),
    .empty    (fl_empty),
    .full     (fl_full)
  );

  // Entry 0 resets to tag 0 and is never written (alloc implies rd != 0),
  // so x0 always reads as tag 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        map_q[i] <= preg_t'(i);
      end
    end else if (alloc) begin
      map_q[rd] <= fl_head;
    end
  end

  // Sources read the pre-update map, so rd == rs sees the old mapping while
  // the next instruction sees the new one with no bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      uop_q       <= '0;
      pulse_q     <= 1'b0;
      target_q    <= '0;
    end else if (accept) begin
      out_valid_q   <= 1'b1;
      uop_q.prs1    <= map_q[rs1];
      uop_q.prs2    <= map_q[rs2];
      uop_q.prd     <= needs_alloc ? fl_head : '0;
      uop_q.old_prd <= needs_alloc ? map_q[rd] : '0;
      pulse_q       <= needs_alloc;
      if (needs_alloc) begin
        target_q <= fl_head;
      end
    end else begin
      pulse_q <= 1'b0;
      if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid       = out_valid_q;
  assign prs1            = uop_q.prs1;
  assign prs2            = uop_q.prs2;
  assign prd             = uop_q.prd;
  assign old_prd         = uop_q.old_prd;
  assign prf_set_not_rdy = pulse_q;
  assign prf_target_reg  = target_q;

`ifndef SYNTHESIS
  // A free into a full list indicates duplicated tags upstream.
  a_no_free_when_full: assert property (@(posedge clk) disable iff (!reset) !(free_req && fl_full))
    else $error("rename_unit: free of tag %0d dropped, free list full", commit_old_prd);
`endif

endmodule

// File: tb/tb_rename_unit.sv
// tb/tb_rename_unit.sv - self-checking bench for rename_unit
module tb_rename_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       rd_wen = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [6:0] prs1, prs2, prd, old_prd;
  logic       prf_set_not_rdy;
  logic [6:0] prf_target_reg;
  logic       commit_free = 1'b0;
  logic [6:0] commit_old_prd = '0;
  logic [6:0] free_count;

  always #5 clk = ~clk;

  rename_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .rd_wen(rd_wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .prs1(prs1), .prs2(prs2), .prd(prd), .old_prd(old_prd),
    .prf_set_not_rdy(prf_set_not_rdy), .prf_target_reg(prf_target_reg),
    .commit_free(commit_free), .commit_old_prd(commit_old_prd),
    .free_count(free_count)
  );

  int total = 0;
  int bad = 0;

  // Reference model: architectural map, queue of free tags, output register image.
  int map_m [32];
  int fl_q [$];
  bit m_ov, m_pulse;
  int m_prs1, m_prs2, m_prd, m_old, m_target;
  bit exp_in_ready, obs_in_ready;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) map_m[i] = i;
    fl_q.delete();
    for (int t = 32; t < 128; t++) fl_q.push_back(t);
    m_ov = 0; m_pulse = 0; m_prs1 = 0; m_prs2 = 0; m_prd = 0; m_old = 0; m_target = 0;
  endtask

  // Drives one cycle starting 1ns after a rising edge and ends 1ns after the next.
  task automatic cycle(input bit iv, input int r1, input int r2, input int d, input bit we,
                       input bit ordy, input bit cf, input int ctag);
    bit alloc, acc;
    int pre_size;
    in_valid = iv; rs1 = 5'(r1); rs2 = 5'(r2); rd = 5'(d); rd_wen = we;
    out_ready = ordy; commit_free = cf; commit_old_prd = 7'(ctag);
    #1;
    alloc = we && (d != 0);
    pre_size = fl_q.size();
    exp_in_ready = (!m_ov || ordy) && (!alloc || pre_size != 0);
    obs_in_ready = in_ready;
    acc = iv && exp_in_ready;
    @(posedge clk); #1;
    if (acc) begin
      m_prs1 = map_m[r1];
      m_prs2 = map_m[r2];
      if (alloc) begin
        m_prd = fl_q.pop_front();
        m_old = map_m[d];
        map_m[d] = m_prd;
        m_pulse = 1;
        m_target = m_prd;
      end else begin
        m_prd = 0; m_old = 0; m_pulse = 0;
      end
      m_ov = 1;
    end else begin
      m_pulse = 0;
      if (ordy) m_ov = 0;
    end
    if (cf && ctag != 0 && pre_size < 96) fl_q.push_back(ctag);
    commit_free = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; rd_wen = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0d want 0", out_valid); end
    total++; if ({prs1, prs2, prd, old_prd} !== 28'd0) begin bad++; $display("FAIL reset_uop: got %h want 0", {prs1, prs2, prd, old_prd}); end
    total++; if (prf_set_not_rdy !== 1'b0) begin bad++; $display("FAIL reset_pulse: got %0d want 0", prf_set_not_rdy); end
    total++; if (prf_target_reg !== 7'd0) begin bad++; $display("FAIL reset_target: got %0d want 0", prf_target_reg); end
    total++; if (free_count !== 7'd96) begin bad++; $display("FAIL reset_free_count: got %0d want 96", free_count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %0d want 0", in_ready); end
    in_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_basic();
    cycle(1, 1, 2, 3, 1, 1, 0, 0);
    total++; if (obs_in_ready !== 1'b1) begin bad++; $display("FAIL add_in_ready: got %0d want 1", obs_in_ready); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_out_valid: got %0d want 1", out_valid); end
    total++; if (prs1 !== 7'd1 || prs2 !== 7'd2) begin bad++; $display("FAIL add_prs: got %0d/%0d want 1/2", prs1, prs2); end
    total++; if (prd !== 7'd32 || old_prd !== 7'd3) begin bad++; $display("FAIL add_prd: got %0d/%0d want 32/3", prd, old_prd); end
    total++; if (prf_set_not_rdy !== 1'b1 || prf_target_reg !== 7'd32) begin bad++; $display("FAIL add_pulse: got %0d/%0d want 1/32", prf_set_not_rdy, prf_target_reg); end
    total++; if (free_count !== 7'd95) begin bad++; $display("FAIL add_free_count: got %0d want 95", free_count); end
    cycle(1, 3, 3, 4, 1, 1, 0, 0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_out_valid: got %0d want 1", out_valid); end
    total++; if (prs1 !== 7'd32 || prs2 !== 7'd32) begin bad++; $display("FAIL b2b_prs: got %0d/%0d want 32/32", prs1, prs2); end
    total++; if (prd !== 7'd33 || old_prd !== 7'd4) begin bad++; $display("FAIL b2b_prd: got %0d/%0d want 33/4", prd, old_prd); end
    total++; if (prf_set_not_rdy !== 1'b1 || prf_target_reg !== 7'd33) begin bad++; $display("FAIL b2b_pulse: got %0d/%0d want 1/33", prf_set_not_rdy, prf_target_reg); end
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    total++; if (out_valid !== 1'b0 || prf_set_not_rdy !== 1'b0) begin bad++; $display("FAIL idle: got valid=%0d pulse=%0d want 0/0", out_valid, prf_set_not_rdy); end
  endtask

  task automatic test_x0();
    cycle(1, 0, 3, 0, 1, 1, 0, 0);
    total++; if (prs1 !== 7'd0 || prs2 !== 7'd32) begin bad++; $display("FAIL x0_prs: got %0d/%0d want 0/32", prs1, prs2); end
    total++; if (prd !== 7'd0 || old_prd !== 7'd0) begin bad++; $display("FAIL x0_prd: got %0d/%0d want 0/0", prd, old_prd); end
    total++; if (prf_set_not_rdy !== 1'b0) begin bad++; $display("FAIL x0_pulse: got %0d want 0", prf_set_not_rdy); end
    total++; if (free_count !== 7'd94) begin bad++; $display("FAIL x0_free_count: got %0d want 94", free_count); end
  endtask

  task automatic test_drain();
    for (int n = 0; n < 200 && fl_q.size() > 0; n++) begin
      cycle(1, $urandom_range(31), $urandom_range(31), $urandom_range(31, 1), 1, 1, 0, 0);
      total++; if (prs1 !== 7'(m_prs1) || prs2 !== 7'(m_prs2)) begin bad++; $display("FAIL drain_prs: got %0d/%0d want %0d/%0d", prs1, prs2, m_prs1, m_prs2); end
      total++; if (prd !== 7'(m_prd) || old_prd !== 7'(m_old)) begin bad++; $display("FAIL drain_prd: got %0d/%0d want %0d/%0d", prd, old_prd, m_prd, m_old); end
      total++; if (free_count !== 7'(fl_q.size()) || prf_set_not_rdy !== 1'b1) begin bad++; $display("FAIL drain_count: got %0d/%0d want %0d/1", free_count, prf_set_not_rdy, fl_q.size()); end
    end
    total++; if (free_count !== 7'd0) begin bad++; $display("FAIL drain_empty: got %0d want 0", free_count); end
    cycle(1, 1, 1, 7, 1, 1, 0, 0);
    total++; if (obs_in_ready !== 1'b0) begin bad++; $display("FAIL empty_alloc_blocked: got %0d want 0", obs_in_ready); end
    cycle(1, 1, 2, 0, 0, 1, 0, 0);
    total++; if (obs_in_ready !== 1'b1 || prd !== 7'd0 || out_valid !== 1'b1) begin bad++; $display("FAIL empty_nonalloc: got rdy=%0d prd=%0d want 1/0", obs_in_ready, prd); end
    cycle(1, 1, 2, 9, 1, 1, 1, 40);
    total++; if (obs_in_ready !== 1'b0) begin bad++; $display("FAIL free_same_cycle: got %0d want 0", obs_in_ready); end
    total++; if (free_count !== 7'd1) begin bad++; $display("FAIL free_count_after: got %0d want 1", free_count); end
    cycle(1, 9, 2, 9, 1, 1, 0, 0);
    total++; if (obs_in_ready !== 1'b1 || prd !== 7'd40) begin bad++; $display("FAIL freed_realloc: got rdy=%0d prd=%0d want 1/40", obs_in_ready, prd); end
    total++; if (free_count !== 7'd0) begin bad++; $display("FAIL freed_count: got %0d want 0", free_count); end
  endtask

  task automatic test_stall();
    logic [27:0] saved;
    logic [6:0]  saved_tgt;
    int          pulses;
    cycle(0, 0, 0, 0, 0, 1, 1, 50);
    cycle(0, 0, 0, 0, 0, 1, 1, 60);
    cycle(0, 0, 0, 0, 0, 1, 1, 70);
    total++; if (free_count !== 7'd3) begin bad++; $display("FAIL stall_prefill: got %0d want 3", free_count); end
    cycle(1, 4, 5, 6, 1, 0, 0, 0);
    total++; if (out_valid !== 1'b1 || prd !== 7'd50) begin bad++; $display("FAIL stall_accept: got valid=%0d prd=%0d want 1/50", out_valid, prd); end
    saved = {prs1, prs2, prd, old_prd};
    saved_tgt = prf_target_reg;
    pulses = int'(prf_set_not_rdy);
    repeat (3) begin
      cycle(1, 7, 8, 9, 1, 0, 0, 0);
      total++; if (obs_in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %0d want 0", obs_in_ready); end
      total++; if (out_valid !== 1'b1 || {prs1, prs2, prd, old_prd} !== saved || prf_target_reg !== saved_tgt) begin bad++; $display("FAIL stall_hold: got %h want %h", {prs1, prs2, prd, old_prd}, saved); end
      pulses += int'(prf_set_not_rdy);
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL stall_pulses: got %0d want 1", pulses); end
    total++; if (free_count !== 7'd2) begin bad++; $display("FAIL stall_count: got %0d want 2", free_count); end
    cycle(0, 0, 0, 0, 0, 1, 0, 0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_release: got %0d want 0", out_valid); end
  endtask

  task automatic test_simul();
    int head;
    for (int n = 0; n < 100 && fl_q.size() > 1; n++) cycle(1, 1, 1, 12, 1, 1, 0, 0);
    for (int n = 0; n < 4 && fl_q.size() == 0; n++) cycle(0, 0, 0, 0, 0, 1, 1, 90);
    head = fl_q[0];
    cycle(1, 1, 1, 10, 1, 1, 1, 7);
    total++; if (obs_in_ready !== 1'b1 || prd !== 7'(head)) begin bad++; $display("FAIL simul_prd: got rdy=%0d prd=%0d want 1/%0d", obs_in_ready, prd, head); end
    total++; if (free_count !== 7'd1) begin bad++; $display("FAIL simul_count: got %0d want 1", free_count); end
    cycle(1, 10, 1, 11, 1, 1, 0, 0);
    total++; if (prd !== 7'd7 || prs1 !== 7'(head)) begin bad++; $display("FAIL simul_next: got prd=%0d prs1=%0d want 7/%0d", prd, prs1, head); end
    total++; if (free_count !== 7'd0) begin bad++; $display("FAIL simul_count2: got %0d want 0", free_count); end
  endtask

  task automatic test_random();
    bit cf;
    for (int n = 0; n < 400; n++) begin
      cf = ($urandom_range(2) == 0) && (fl_q.size() < 96);
      cycle($urandom_range(3) != 0, $urandom_range(31), $urandom_range(31), $urandom_range(31),
            $urandom_range(3) != 0, $urandom_range(2) != 0, cf,
            ($urandom_range(7) == 0) ? 0 : $urandom_range(127, 1));
      total++; if (obs_in_ready !== exp_in_ready) begin bad++; $display("FAIL rnd_in_ready[%0d]: got %0d want %0d", n, obs_in_ready, exp_in_ready); end
      total++; if (out_valid !== m_ov) begin bad++; $display("FAIL rnd_out_valid[%0d]: got %0d want %0d", n, out_valid, m_ov); end
      total++; if (prs1 !== 7'(m_prs1) || prs2 !== 7'(m_prs2)) begin bad++; $display("FAIL rnd_prs[%0d]: got %0d/%0d want %0d/%0d", n, prs1, prs2, m_prs1, m_prs2); end
      total++; if (prd !== 7'(m_prd) || old_prd !== 7'(m_old)) begin bad++; $display("FAIL rnd_prd[%0d]: got %0d/%0d want %0d/%0d", n, prd, old_prd, m_prd, m_old); end
      total++; if (prf_set_not_rdy !== m_pulse || prf_target_reg !== 7'(m_target)) begin bad++; $display("FAIL rnd_pulse[%0d]: got %0d/%0d want %0d/%0d", n, prf_set_not_rdy, prf_target_reg, m_pulse, m_target); end
      total++; if (free_count !== 7'(fl_q.size())) begin bad++; $display("FAIL rnd_free_count[%0d]: got %0d want %0d", n, free_count, fl_q.size()); end
    end
  endtask

  task automatic test_reset_mid();
    int a, b;
    cycle(1, 1, 2, 0, 0, 1, 0, 0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %0d want 1", out_valid); end
    #2; reset = 1'b0; #1;
    total++; if (out_valid !== 1'b0 || free_count !== 7'd96) begin bad++; $display("FAIL mid_async: got valid=%0d count=%0d want 0/96", out_valid, free_count); end
    total++; if (in_ready !== 1'b0 || prf_set_not_rdy !== 1'b0) begin bad++; $display("FAIL mid_in_ready: got %0d want 0", in_ready); end
    in_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      a = $urandom_range(31); b = $urandom_range(31);
      cycle(1, a, b, 0, 0, 1, 0, 0);
      total++; if (prs1 !== 7'(a) || prs2 !== 7'(b)) begin bad++; $display("FAIL mid_identity: got %0d/%0d want %0d/%0d", prs1, prs2, a, b); end
    end
    cycle(1, 3, 4, 3, 1, 1, 0, 0);
    total++; if (prd !== 7'd32 || old_prd !== 7'd3) begin bad++; $display("FAIL mid_alloc: got %0d/%0d want 32/3", prd, old_prd); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_x0();
    test_drain();
    test_stall();
    test_simul();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
